bt_update_queue: RTL and testbench
==================================

// Module: bt_update_queue
// PURPOSE
//  Receives BTUpdate pulses from branch-capable IntALU instances (indirect-jump target corrections).
//  Buffers them in an in-order FIFO and drains them into the BTB write port under a valid/ready handshake.
//  Also owns the BTB clean sweep: invalidates every BTB entry after reset and on IN_clearBTB.
//  Sits between the execute-stage branch units and the BTB in the front end.
// PARAMETERS
//  NUM_IN       2   number of BTUpdate source ports (one per branch-capable ALU)
//  DEPTH        4   FIFO entries (power of two, >=2)
//  BTB_ENTRIES  64  BTB sets touched by a clean sweep (power of two)
//  IDX_LSB      1   lsb of the BTB index within src (halfword-aligned PCs)
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous active-high reset
//  IN_btUpdate  in   NUM_IN x $bits(BTUpdate) one-cycle update pulses; .valid qualifies; no backpressure
//  IN_clearBTB  in   1                      pulse: flush FIFO and start a clean sweep
//  IN_ready     in   1                      BTB write port accepts OUT_btUpdate this cycle
//  OUT_btUpdate out  $bits(BTUpdate)         BTB write request; .valid qualifies
//  OUT_busy     out  1                      high while a clean sweep is in progress
//  OUT_dropCnt  out  16                     saturating count of updates dropped (full/sweep)
// BEHAVIOUR
//  Reset: synchronous, active-high.
//   - While rst is high: OUT_btUpdate.valid=0, OUT_busy=0, OUT_dropCnt=0.
//   - While rst is high: FIFO is emptied and the sweep index is cleared.
//   - First cycle after rst falls: FSM enters SWEEP.
//  FSM states:
//   - SWEEP: OUT_busy=1.
//     - OUT_btUpdate.valid=1, .clean=1, .src[IDX_LSB+:log2(BTB_ENTRIES)]=idx; all other fields 0.
//     - idx increments only on the cycle valid&&IN_ready.
//     - After the handshake at idx=BTB_ENTRIES-1, goes to RUN and idx returns to 0.
//     - Input pulses are dropped in SWEEP.
//   - RUN: OUT_btUpdate = FIFO head with .clean=0; .valid = FIFO non-empty.
//     - The head pops on valid&&IN_ready.
//  IN_clearBTB (any state, rst low):
//   - Same cycle: FIFO empties, idx goes to 0, FSM goes to SWEEP.
//   - Updates arriving that cycle are dropped and counted.
//  IN_clearBTB during SWEEP restarts the sweep at idx=0.
//  Handshake:
//   - OUT_btUpdate is registered.
//   - Once valid, it holds every field stable until IN_ready is seen high.
//   - valid never drops without a handshake, except on rst or IN_clearBTB.
//  Latency: an update accepted in cycle N, into an empty FIFO, in RUN with IN_ready=1, is presented valid in cycle N+1.
//  Enqueue:
//   - Inputs are scanned from port 0 upward; each valid input takes the next free slot.
//   - Order in the FIFO is (cycle, port index).
//   - Free slots are counted including the slot freed by a same-cycle pop.
//  Full FIFO: excess inputs are dropped (BTB updates are hints).
//   - OUT_dropCnt += number dropped that cycle, saturating at 16'hFFFF.
//  Duplicate in the same cycle: when two valid inputs carry an equal src[31:1], only the lowest port is enqueued.
//   - The duplicate is not counted as a drop.
//  Simultaneous enqueue and dequeue are legal in the same cycle, including when the FIFO is full.
//  Pointers: log2(DEPTH)+1 bits with a wrap bit.
//   - full = index bits equal and wrap bits differ; empty = pointers equal.
//  Entries are stored exactly as received.
// TESTING
//  - rst 1 cycle, IN_ready=1 -> 64 consecutive clean writes, idx 0..63.
//    - OUT_busy falls the cycle after idx 63; dropCnt=0.
//  - RUN: port0 pulse src=0x1000, dst=0x2000 -> OUT valid next cycle with identical fields, clean=0.
//    - Hold IN_ready=0 for 3 cycles -> fields stable; pops on the 4th cycle.
//  - IN_ready=0: 6 pulses on port0 over 6 cycles -> 4 queued, dropCnt=2.
//    - Then IN_ready=1 -> the 4 drain in arrival order.
//  - Port0 src=0x100 and port1 src=0x200 in the same cycle -> 0x100 out before 0x200.
//    - Both ports src=0x100 -> a single entry, dropCnt unchanged.
//  - IN_clearBTB with 3 queued and IN_ready=0 -> queue discarded, sweep restarts at idx 0.
//    - A port0 pulse in that cycle increments dropCnt.
//  - Assert rst mid-sweep at idx=20 -> outputs zero during rst; the sweep restarts at idx 0 afterwards.

Source files
------------

// File: rtl/bt_update_queue.sv
// BTB update queue: buffers branch-target corrections from the ALUs into an in-order FIFO
// and drains them into the BTB write port; also runs the BTB clean sweep after reset/clear.
package btUpdatePkg;
  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic        clean;
    logic        valid;
  } BTUpdate;
endpackage

module bt_update_queue
  import btUpdatePkg::*;
#(
  parameter int NUM_IN      = 2,
  parameter int DEPTH       = 4,
  parameter int BTB_ENTRIES = 64,
  parameter int IDX_LSB     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  BTUpdate     IN_btUpdate [NUM_IN],
  input  logic        IN_clearBTB,
  input  logic        IN_ready,
  output BTUpdate     OUT_btUpdate,
  output logic        OUT_busy,
  output logic [15:0] OUT_dropCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(BTB_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, RUN} State;

  State          state, nextState;
  BTUpdate       mem [DEPTH];
  BTUpdate       outReg, nextOut, nextHead, firstWritten;
  logic [AW:0]   rdPtr, wrPtr, rdNext, count, free, taken;
  logic [IW-1:0] idx;
  logic [15:0]   dropCnt, nDrop;
  logic [16:0]   dropSum;
  logic          pop, accept, sweepHs, dup;
  logic          wrEn  [NUM_IN];
  logic [AW-1:0] wrOff [NUM_IN];

  function automatic BTUpdate sweepEntry(input logic [IW-1:0] i);
    BTUpdate e;
    e = '0;
    e.valid = 1'b1;
    e.clean = 1'b1;
    e.src[IDX_LSB +: IW] = i;
    return e;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (IN_clearBTB) nextState = SWEEP;
    else begin
      case (state)
        IDLE:    nextState = SWEEP;
        SWEEP:   if (sweepHs && idx == LAST_IDX) nextState = RUN;
        default: nextState = RUN;
      endcase
    end
  end

  // Enqueue scan: lowest port wins on duplicate src, free slots include a same-cycle pop.
  always_comb begin
    accept  = (state == RUN) && !IN_clearBTB;
    pop     = (state == RUN) && outReg.valid && IN_ready;
    sweepHs = (state == SWEEP) && outReg.valid && IN_ready;
    count   = wrPtr - rdPtr;
    free    = DEPTH_W - count + {{AW{1'b0}}, pop};
    taken   = '0;
    nDrop   = '0;
    firstWritten = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      wrEn[i]  = 1'b0;
      wrOff[i] = '0;
      dup      = 1'b0;
      for (int j = 0; j < i; j++)
        if (IN_btUpdate[j].valid && IN_btUpdate[j].src[31:1] == IN_btUpdate[i].src[31:1])
          dup = 1'b1;
      if (IN_btUpdate[i].valid && !dup) begin
        if (accept && taken < free) begin
          wrEn[i]  = 1'b1;
          wrOff[i] = taken[AW-1:0];
          if (taken == '0) firstWritten = IN_btUpdate[i];
          taken = taken + 1'b1;
        end else begin
          nDrop = nDrop + 1'b1;
        end
      end
    end
    rdNext   = rdPtr + {{AW{1'b0}}, pop};
    nextHead = '0;
    if (rdNext != wrPtr) nextHead = mem[rdNext[AW-1:0]];
    else if (taken != '0) nextHead = firstWritten;
    nextHead.clean = 1'b0;
    nextHead.valid = (rdNext != wrPtr + taken);
  end

  always_comb begin
    OUT_busy = (state == SWEEP);
    nextOut  = outReg;
    if (IN_clearBTB || state == IDLE) nextOut = sweepEntry('0);
    else if (state == SWEEP) begin
      if (sweepHs) nextOut = (idx == LAST_IDX) ? BTUpdate'('0) : sweepEntry(idx + 1'b1);
    end else nextOut = nextHead;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outReg  <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      idx     <= '0;
      dropCnt <= '0;
    end else begin
      outReg  <= nextOut;
      dropCnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      if (IN_clearBTB) begin
        rdPtr <= '0;
        wrPtr <= '0;
        idx   <= '0;
      end else begin
        rdPtr <= rdNext;
        wrPtr <= wrPtr + taken;
        if (sweepHs) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < NUM_IN; i++)
        if (wrEn[i]) mem[wrPtr[AW-1:0] + wrOff[i]] <= IN_btUpdate[i];
  end

  assign dropSum      = 17'(dropCnt) + 17'(nDrop);
  assign OUT_btUpdate = outReg;
  assign OUT_dropCnt  = dropCnt;

endmodule

// File: tb/tb_bt_update_queue.sv
// Directed bench for bt_update_queue: table of RUN-mode vectors plus hand-written
// sweep, clear and reset sequences. Port0 dst = src<<1, port1 dst = (src<<1)|1.
module tb_bt_update_queue;
  import btUpdatePkg::*;

  typedef struct {
    logic        v0;
    logic [31:0] s0;
    logic        v1;
    logic [31:0] s1;
    logic        ready;
    logic        expValid;
    logic [31:0] expSrc;
    logic        expPort;
    logic [15:0] expDrop;
  } Vec;

  logic        clk = 1'b0;
  logic        rst;
  BTUpdate     inUpd [2];
  logic        clearBtb;
  logic        ready;
  BTUpdate     outUpd;
  logic        busy;
  logic [15:0] dropCnt;
  int          checks = 0;
  int          passes = 0;
  Vec          vecs[$];

  always #5 clk = ~clk;

  bt_update_queue #(.NUM_IN(2), .DEPTH(4), .BTB_ENTRIES(64), .IDX_LSB(1)) dut (
    .clk(clk), .rst(rst), .IN_btUpdate(inUpd), .IN_clearBTB(clearBtb),
    .IN_ready(ready), .OUT_btUpdate(outUpd), .OUT_busy(busy), .OUT_dropCnt(dropCnt)
  );

  function automatic Vec mk(input logic v0, input logic [31:0] s0, input logic v1,
                            input logic [31:0] s1, input logic rdy, input logic ev,
                            input logic [31:0] es, input logic ep, input logic [15:0] ed);
    Vec v;
    v.v0 = v0; v.s0 = s0; v.v1 = v1; v.s1 = s1; v.ready = rdy;
    v.expValid = ev; v.expSrc = es; v.expPort = ep; v.expDrop = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int port, input logic [31:0] src);
    inUpd[port].valid = 1'b1;
    inUpd[port].clean = 1'b0;
    inUpd[port].src   = src;
    inUpd[port].dst   = (src << 1) | 32'(port);
  endtask

  task automatic idleInputs();
    inUpd[0] = '0;
    inUpd[1] = '0;
    clearBtb = 1'b0;
  endtask

  task automatic applyStimulus(input Vec v);
    idleInputs();
    if (v.v0) pulse(0, v.s0);
    if (v.v1) pulse(1, v.s1);
    ready = v.ready;
    step();
  endtask

  task automatic checkSweep(input string name, input int k);
    checkOutput({name, "Src"}, 64'(outUpd.src), 64'(k << 1));
    checkOutput({name, "Flags"}, {61'd0, outUpd.valid, outUpd.clean, busy}, 64'h7);
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    idleInputs();
    step();
    checkOutput("resetState", {outUpd.valid, busy, dropCnt}, 64'h0);
    rst = 1'b0;

    for (int k = 0; k < 64; k++) begin
      step();
      checkSweep("sweep", k);
    end
    step();
    checkOutput("sweepDone", {outUpd.valid, busy, dropCnt}, 64'h0);

    // RUN-mode vectors: latency/hold, overflow drops, port order, duplicates, full with pop
    vecs.push_back(mk(1, 32'h1000, 0, 0, 1, 1, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h20, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h30, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 1, 32'h10, 0, 0));
    vecs.push_back(mk(1, 32'h50, 0, 0, 0, 1, 32'h10, 0, 1));
    vecs.push_back(mk(1, 32'h60, 0, 0, 0, 1, 32'h10, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h20, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h30, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h40, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h200, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 1, 32'h100, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 32'hA00, 0, 0, 0, 1, 32'hA00, 0, 2));
    vecs.push_back(mk(1, 32'hB00, 0, 0, 0, 1, 32'hA00, 0, 2));
    vecs.push_back(mk(1, 32'hC00, 0, 0, 0, 1, 32'hA00, 0, 2));
    vecs.push_back(mk(1, 32'hD00, 0, 0, 0, 1, 32'hA00, 0, 2));
    vecs.push_back(mk(1, 32'hE00, 0, 0, 1, 1, 32'hB00, 0, 2));
    vecs.push_back(mk(1, 32'hF00, 1, 32'hF10, 0, 1, 32'hB00, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'hC00, 0, 4));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d.valid", i), 64'(outUpd.valid), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.drop", i), 64'(dropCnt), 64'(vecs[i].expDrop));
      checkOutput($sformatf("vec%0d.busy", i), 64'(busy), 64'h0);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d.src", i), 64'(outUpd.src), 64'(vecs[i].expSrc));
        checkOutput($sformatf("vec%0d.dst", i), 64'(outUpd.dst),
                    64'((vecs[i].expSrc << 1) | 32'(vecs[i].expPort)));
        checkOutput($sformatf("vec%0d.clean", i), 64'(outUpd.clean), 64'h0);
      end
    end
    idleInputs();

    // Clear with 3 queued and IN_ready low; the same-cycle pulse counts as a drop
    clearBtb = 1'b1;
    ready = 1'b0;
    pulse(0, 32'h700);
    step();
    idleInputs();
    checkSweep("clearIdx0", 0);
    checkOutput("clearDrop", 64'(dropCnt), 64'd5);
    step();
    checkSweep("sweepHold", 0);

    ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) pulse(1, 32'h900);
      step();
      idleInputs();
    end
    checkSweep("sweepIdx20", 20);
    checkOutput("sweepDrop", 64'(dropCnt), 64'd6);

    rst = 1'b1;
    step();
    checkOutput("midSweepReset", {outUpd.valid, busy, dropCnt}, 64'h0);
    rst = 1'b0;
    step();
    checkSweep("postResetIdx0", 0);
    step();
    step();
    step();
    checkSweep("postResetIdx3", 3);

    clearBtb = 1'b1;
    step();
    idleInputs();
    checkSweep("restartIdx0", 0);

    begin
      int n;
      n = 0;
      while (busy && n < 100) begin
        step();
        n++;
      end
      checkOutput("sweepLength", 64'(n), 64'd64);
      checkOutput("sweepEndState", {outUpd.valid, busy}, 64'h0);
    end

    pulse(1, 32'h3330);
    step();
    idleInputs();
    checkOutput("port1Latency", {outUpd.valid, outUpd.clean, outUpd.src, outUpd.dst},
                {1'b1, 1'b0, 32'h3330, 32'h6661});
    step();
    checkOutput("port1Drain", 64'(outUpd.valid), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
